imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into the instruction-memory write port. The CPU only reads that memory, and its write port is otherwise unused. The loader holds the CPU in reset through `cpu_hold` until a complete, valid image has been written.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: maximum image size in words. A header count above this value is an error.
- `BASE_ADDR`, default 32'h0: byte address of the first word written.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a load. It is honoured only in IDLE, DONE or ERR.
- `byte_valid`, input, 1: source has a byte on `byte_data`.
- `byte_data`, input, 8: stream byte.
- `byte_ready`, output, 1: loader accepts a byte this cycle. A byte is transferred when `byte_valid` and `byte_ready` are both high.
- `mem_addr`, output, 32: instruction-memory byte address.
- `mem_wdata`, output, 32: word to write.
- `mem_we`, output, 1: one-cycle write strobe.
- `cpu_hold`, output, 1: drive into the CPU `rst`. High means the CPU is held.
- `done`, output, 1: image loaded successfully. Stays high until the next `start` or `rst`.
- `error`, output, 1: load aborted. Stays high until the next `start` or `rst`.
- `word_count`, output, 16: number of words written so far in the current load.

## Operation
- Stream format:
  - Two header bytes carry N, big-endian, 16 bits.
  - Then 4·N data bytes. Each word is MSB first.
  - With the checksum feature compiled in, one trailing checksum byte follows.
- States:
  - IDLE → HDR0 on `start`.
  - HDR0 → HDR1 on byte accept. The byte goes to N[15:8].
  - HDR1 → on byte accept, the byte goes to N[7:0]. Then:
    - ERR if N==0 or N>DEPTH_WORDS.
    - Otherwise DATA, with byte index 0, address = BASE_ADDR, and `word_count`=0.
  - DATA: each accepted byte shifts into the word register.
    - On the 4th byte → WRITE.
  - WRITE (one cycle): `mem_we`=1 and `word_count` increments.
    - Next state: DATA if words remain. Otherwise CHK (checksum build) or DONE.
    - The address advances by 4 after the write.
  - CHK: one byte accept, then DONE if it matches, ERR if not.
  - DONE and ERR → HDR0 on `start`.
- `byte_ready` is high only in HDR0, HDR1, DATA and CHK. It is low in IDLE, WRITE, DONE and ERR.
- `mem_addr` and `mem_wdata` are registered and stable for the whole WRITE cycle. `mem_we` is never high outside WRITE.
- `cpu_hold`:
  - High from reset and throughout any load.
  - Falls on entry to DONE.
  - Stays high in ERR.
  - Rises again on a re-`start` from DONE.
- A `start` while a load is in progress (HDR0 through CHK) is ignored.
- `rst` mid-load returns all state and outputs to reset values. Memory words already written are not cleared.
- Address arithmetic is 32-bit and wraps modulo 2^32. No bounds check is made beyond DEPTH_WORDS.

## Timing
- Reset values:
  - `byte_ready`=0, `mem_we`=0, `done`=0, `error`=0.
  - `cpu_hold`=1.
  - `mem_addr`=BASE_ADDR, `mem_wdata`=0, `word_count`=0.
  - State = IDLE.
- `start` at cycle t → `byte_ready`=1 at t+1.
- 4th byte of a word accepted at cycle k:
  - `mem_we`=1 at k+1.
  - `byte_ready`=0 at k+1, and high again at k+2 if more bytes are expected.
- Sustained throughput is 4 bytes per 5 cycles.
- Last write at cycle w (no checksum): `done`=1 and `cpu_hold`=0 at w+1.
- Header error detected on the HDR1 accept at cycle h: `error`=1 at h+1. No memory write occurs.
- Bytes presented while `byte_ready`=0 are not consumed. The source must hold them.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all 4·N data bytes is kept.
  - After the last WRITE the loader enters CHK and accepts one byte.
  - If it equals the XOR → DONE. Otherwise → ERR, with `cpu_hold` held high.
  - The header bytes are excluded from the XOR.
- Undefined:
  - No CHK state and no XOR register.
  - The loader goes from the last WRITE directly to DONE.

## Test plan
- Basic load: N=2, bytes 00 02 | 20 08 00 05 | 00 00 00 0C with no gaps. Expect:
  - Write 32'h20080005 at address 0x0, then 32'h0000000C at 0x4.
  - `word_count`=2, `done`=1, `cpu_hold`=0.
- Header errors, each in its own run:
  - N=0 (00 00) → `error`=1 one cycle after the 2nd byte, with no `mem_we`.
  - N=257 with DEPTH_WORDS=256 → same response.
- Backpressure and gaps: the source holds `byte_valid`=1 continuously. Check:
  - No byte is lost or duplicated across the WRITE cycle.
  - Idle gaps of 3 cycles between bytes produce the same memory image.
- Reset mid-load: assert `rst` after 6 data bytes. Expect all outputs at reset values, including `cpu_hold`=1, state IDLE, and no further `mem_we`. A following `start` loads cleanly.
- Checksum, built with `IMEM_LOADER_CHECKSUM_EN`:
  - N=1, word 12 34 56 78, checksum 08 → DONE.
  - Same word with checksum 09 → `error`=1 and `cpu_hold`=1. The word at BASE_ADDR is still written.
- Restart: `start` from DONE → `cpu_hold`=1 and `done`=0 next cycle. A second image with BASE_ADDR=0x100 writes to 0x100, 0x104, and so on.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction-memory loader. Receives a byte stream over
//            a valid/ready handshake (2-byte big-endian word count N, then
//            4*N data bytes, MSB first per word), writes the assembled words
//            to the instruction-memory write port and holds the CPU in reset
//            until a complete image has been written.
// Optional : IMEM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte
//            (XOR of all data bytes) is expected and verified before DONE.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            start            - begin a load (honoured in IDLE/DONE/ERR)
//            byte_valid/data  - byte stream from the source
//            byte_ready       - loader can take a byte this cycle
//            mem_addr/wdata/we- instruction-memory write port
//            cpu_hold         - CPU reset hold (high = held)
//            done, error      - sticky completion / abort flags
//            word_count       - words written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] c_DEPTH_WORDS = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_ERR   = 3'd6,
    S_CHK   = 3'd7
`else
    S_ERR   = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] word_count_q, word_count_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic        w_accept;
  logic [15:0] w_n_full;
  logic        w_last_word;

  // Ready depends only on the state, so it never combinationally follows valid.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                  byte_ready = 1'b1;
`endif
      default:                byte_ready = 1'b0;
    endcase
  end

  assign w_accept    = byte_valid & byte_ready;
  assign w_n_full    = {n_q[15:8], byte_data};
  assign w_last_word = ((word_count_q + 16'd1) == n_q);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    word_d       = word_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    error_d      = error_q;
    cpu_hold_d   = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_HDR0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          cpu_hold_d   = 1'b1;
          word_count_d = 16'd0;
        end
      end
      S_HDR0: begin
        if (w_accept) begin
          n_d[15:8] = byte_data;
          state_d   = S_HDR1;
        end
      end
      S_HDR1: begin
        if (w_accept) begin
          n_d = w_n_full;
          if ((w_n_full == 16'd0) || ({16'd0, w_n_full} > c_DEPTH_WORDS)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d      = S_DATA;
            idx_d        = 2'd0;
            addr_d       = BASE_ADDR;
            word_count_d = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d        = 8'd0;
`endif
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          // Shift in MSB first; after four bytes word_q holds the full word
          // and doubles as the registered write data during WRITE.
          word_d = {word_q[23:0], byte_data};
          idx_d  = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + 16'd1;
        addr_d       = addr_q + 32'd4;
        if (!w_last_word) begin
          state_d = S_DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          if (byte_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= 16'd0;
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      addr_q       <= BASE_ADDR;
      word_count_q <= 16'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign mem_we     = (state_q == S_WRITE);
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Stimulus pushes the expected
//            memory writes (derived from the byte image) into a queue; a
//            monitor pops and compares on every mem_we.
// Optional : IMEM_LOADER_CHECKSUM_EN - images get a trailing XOR byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] img[$];
  logic [7:0] img_copy[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  // Reference model: word i of the image lands at BASE+4i, bytes MSB first.
  // Only words whose four bytes are among the first nsent bytes are expected.
  task automatic model_writes(input int nsent);
    int  n;
    wr_t w;
    n = {img[0], img[1]};
    for (int i = 0; i < n; i++) begin
      if (2 + 4 * i + 3 < nsent) begin
        w.addr = BASE + 32'(4 * i);
        w.data = {img[2 + 4 * i], img[3 + 4 * i], img[4 + 4 * i], img[5 + 4 * i]};
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    for (int i = 2; i < img.size(); i++) x = x ^ img[i];
    img.push_back(x);
`endif
  endtask

  task automatic build_image(input int n);
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    add_checksum();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got no ready for byte %h, expected ready within 64 cycles", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    chk({tag, "_done"},       {31'd0, done},       32'd0);
    chk({tag, "_error"},      {31'd0, error},      32'd0);
    chk({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd1);
    chk({tag, "_mem_addr"},   mem_addr,            BASE);
    chk({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    chk({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
  endtask

  // Full load of the current image; expectations follow from its header.
  task automatic run_load(input int gap, input bit mid_start);
    int n;
    bit ok;
    n  = {img[0], img[1]};
    ok = (n != 0) && (n <= DEPTH);
    pulse_start();
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    chk("start_hold",  {31'd0, cpu_hold},   32'd1);
    chk("start_done",  {31'd0, done},       32'd0);
    if (ok) model_writes(img.size());
    for (int i = 0; i < img.size(); i++) begin
      if (mid_start && i == 4) start = 1'b1;
      send_byte(img[i], gap);
      start = 1'b0;
    end
    byte_valid = 1'b0;
    if (!ok) begin
      chk("hdr_err_error", {31'd0, error},      32'd1);
      chk("hdr_err_hold",  {31'd0, cpu_hold},   32'd1);
      chk("hdr_err_done",  {31'd0, done},       32'd0);
      chk("hdr_err_ready", {31'd0, byte_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
    end else begin
`ifndef IMEM_LOADER_CHECKSUM_EN
      @(posedge clk);
      #1;
`endif
      chk("load_done",       {31'd0, done},       32'd1);
      chk("load_hold",       {31'd0, cpu_hold},   32'd0);
      chk("load_error",      {31'd0, error},      32'd0);
      chk("load_word_count", {16'd0, word_count}, 32'(n));
      chk("load_pending",    32'(exp_q.size()),   32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    #1;
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed basic load.
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    add_checksum();
    run_load(0, 1'b0);

    // Header errors: zero, one past depth, random oversize.
    img = '{8'h00, 8'h00};
    run_load(0, 1'b0);
    img = '{8'h01, 8'h01};
    run_load(1, 1'b0);
    img.delete();
    img.push_back(8'($urandom_range(2, 255)));
    img.push_back(8'($urandom));
    run_load(0, 1'b0);

    // Same image with and without 3-cycle gaps.
    build_image(5);
    img_copy = img;
    run_load(0, 1'b0);
    img = img_copy;
    run_load(3, 1'b0);

    // Maximum legal image.
    build_image(DEPTH);
    run_load(0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load(0, 1'b0);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    pulse_start();
    model_writes(img.size());
    for (int i = 0; i < img.size(); i++) send_byte(img[i], 0);
    byte_valid = 1'b0;
    chk("bad_chk_error", {31'd0, error},    32'd1);
    chk("bad_chk_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("bad_chk_done",  {31'd0, done},     32'd0);
    chk("bad_chk_pend",  32'(exp_q.size()), 32'd0);
`endif

    // Reset after 6 data bytes: first word written, then nothing more.
    build_image(3);
    pulse_start();
    model_writes(8);
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_reset_values("postrst");
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);

    // Randomised loads, some with a start pulse mid-load that must be ignored.
    for (int k = 0; k < 12; k++) begin
      build_image(int'($urandom_range(1, 8)));
      run_load((k % 3 == 0) ? 3 : int'($urandom_range(0, 1)), (k % 4 == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
